// File: rtl/mips_bp_pkg.sv
// Shared branch-predictor types: the queue entry layout and the default PC index width.
package mips_bp_pkg;

  localparam int BP_ADDR_WIDTH_DEFAULT = 6;

  typedef struct packed {
    logic [BP_ADDR_WIDTH_DEFAULT-1:0] addr;
    logic                             pred;
  } bp_entry_t;

endpackage

// File: rtl/branch_resolution_queue_if.sv
// Fetch/execute <-> branch resolution queue bus. Stats outputs exist only when
// BRQ_STATS_EN is defined.
interface branch_resolution_queue_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  enqValid;
  logic [ADDR_WIDTH-1:0] enqAddr;
  logic                  enqPred;
  logic                  resolveValid;
  logic                  resolveTaken;
  logic                  flush;
  logic                  full;
  logic                  empty;
  logic [CW-1:0]         count;
  logic                  update;
  logic [ADDR_WIDTH-1:0] updateAddr;
  logic                  branchTaken;
  logic                  mispredict;
`ifdef BRQ_STATS_EN
  logic [31:0]           statResolved;
  logic [31:0]           statMispredict;

  modport master (
    output enqValid, enqAddr, enqPred, resolveValid, resolveTaken, flush,
    input  full, empty, count, update, updateAddr, branchTaken, mispredict,
           statResolved, statMispredict
  );
  modport slave (
    input  enqValid, enqAddr, enqPred, resolveValid, resolveTaken, flush,
    output full, empty, count, update, updateAddr, branchTaken, mispredict,
           statResolved, statMispredict
  );
`else
  modport master (
    output enqValid, enqAddr, enqPred, resolveValid, resolveTaken, flush,
    input  full, empty, count, update, updateAddr, branchTaken, mispredict
  );
  modport slave (
    input  enqValid, enqAddr, enqPred, resolveValid, resolveTaken, flush,
    output full, empty, count, update, updateAddr, branchTaken, mispredict
  );
`endif
endinterface

// File: rtl/branch_resolution_queue_storage.sv
// DEPTH-entry register file for in-flight branches: one write port, async read of the head.
module brq_storage
  import mips_bp_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = bp_entry_t
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  entry_t                   wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output entry_t                   rdata
);

  // No reset: a slot is only read after it has been written.
  entry_t [DEPTH-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk) mem_q <= mem_d;

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/branch_resolution_queue.sv
// In-flight branch tracker between fetch and execute; trains the predictor on resolve.
// Optional BRQ_STATS_EN adds saturating resolved/mispredict counters.
module branch_resolution_queue
  import mips_bp_pkg::*;
#(
  parameter int ADDR_WIDTH = BP_ADDR_WIDTH_DEFAULT,
  parameter int DEPTH      = 4
) (
  input logic                     clk,
  input logic                     rst,
  branch_resolution_queue_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  pred;
  } entry_t;

  logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  update_q, update_d;
  logic [ADDR_WIDTH-1:0] update_addr_q, update_addr_d;
  logic                  branch_taken_q, branch_taken_d;
  logic                  mispredict_q, mispredict_d;

  entry_t head_entry, wr_entry;
  logic   is_full, is_empty, do_pop, do_push, mis_raw, clear;

  assign wr_entry = '{addr: bus.enqAddr, pred: bus.enqPred};

  brq_storage #(.DEPTH(DEPTH), .entry_t(entry_t)) u_storage (
    .clk   (clk),
    .we    (do_push),
    .waddr (tail_q),
    .wdata (wr_entry),
    .raddr (head_q),
    .rdata (head_entry)
  );

  always_comb begin
    is_full  = (count_q == CW'(DEPTH));
    is_empty = (count_q == '0);
    do_pop   = bus.resolveValid && !is_empty;
    mis_raw  = do_pop && (head_entry.pred != bus.resolveTaken);
    clear    = bus.flush || mis_raw;
    // A correct pop frees the head slot this cycle, so it unblocks a push while full.
    do_push  = bus.enqValid && (!is_full || do_pop) && !clear;

    head_d  = head_q + PW'(do_pop);
    tail_d  = tail_q + PW'(do_push);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
    if (clear) begin
      head_d  = tail_q;
      tail_d  = tail_q;
      count_d = '0;
    end

    update_d       = do_pop;
    update_addr_d  = do_pop ? head_entry.addr : update_addr_q;
    branch_taken_d = do_pop ? bus.resolveTaken : branch_taken_q;
    mispredict_d   = mis_raw && !bus.flush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      update_q       <= 1'b0;
      update_addr_q  <= '0;
      branch_taken_q <= 1'b0;
      mispredict_q   <= 1'b0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      update_q       <= update_d;
      update_addr_q  <= update_addr_d;
      branch_taken_q <= branch_taken_d;
      mispredict_q   <= mispredict_d;
    end
  end

  assign bus.full        = is_full;
  assign bus.empty       = is_empty;
  assign bus.count       = count_q;
  assign bus.update      = update_q;
  assign bus.updateAddr  = update_addr_q;
  assign bus.branchTaken = branch_taken_q;
  assign bus.mispredict  = mispredict_q;

`ifdef BRQ_STATS_EN
  logic [31:0] stat_resolved_q, stat_resolved_d;
  logic [31:0] stat_mispredict_q, stat_mispredict_d;

  // Counters survive flush; only rst clears them.
  always_comb begin
    stat_resolved_d   = stat_resolved_q;
    stat_mispredict_d = stat_mispredict_q;
    if (do_pop && stat_resolved_q != '1)   stat_resolved_d   = stat_resolved_q + 32'd1;
    if (mis_raw && stat_mispredict_q != '1) stat_mispredict_d = stat_mispredict_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_resolved_q   <= '0;
      stat_mispredict_q <= '0;
    end else begin
      stat_resolved_q   <= stat_resolved_d;
      stat_mispredict_q <= stat_mispredict_d;
    end
  end

  assign bus.statResolved   = stat_resolved_q;
  assign bus.statMispredict = stat_mispredict_q;
`endif

endmodule

// File: tb/tb_branch_resolution_queue.sv
// Self-checking bench for branch_resolution_queue: vector table plus a queue model and
// an update scoreboard; stats checks compile in with BRQ_STATS_EN.
module tb_branch_resolution_queue;
  localparam int AW = 6;
  localparam int D  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_resolution_queue_if #(.ADDR_WIDTH(AW), .DEPTH(D)) bus ();

  branch_resolution_queue #(.ADDR_WIDTH(AW), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit enq; int addr; bit pred; bit res; bit taken; bit fl;
    int exp_count; bit exp_update; bit exp_mis;
  } vec_t;
  typedef struct { int addr; bit pred; } ent_t;
  typedef struct { int addr; bit taken; bit mis; } upd_t;

  vec_t tbl[$];
  ent_t mq[$];
  upd_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   last_addr = 0;
  bit   last_taken = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.enqValid = 0; bus.enqAddr = '0; bus.enqPred = 0;
    bus.resolveValid = 0; bus.resolveTaken = 0; bus.flush = 0;
  endtask

  task automatic check_outputs();
    upd_t u;
    chk("count", bus.count, mq.size());
    chk("full", bus.full, mq.size() == D);
    chk("empty", bus.empty, mq.size() == 0);
    if (sb.size() > 0) begin
      u = sb.pop_front();
      chk("update", bus.update, 1);
      chk("updateAddr", bus.updateAddr, u.addr);
      chk("branchTaken", bus.branchTaken, u.taken);
      chk("mispredict", bus.mispredict, u.mis);
      last_addr  = u.addr;
      last_taken = u.taken;
    end else begin
      chk("update_idle", bus.update, 0);
      chk("mispredict_idle", bus.mispredict, 0);
      chk("updateAddr_hold", bus.updateAddr, last_addr);
      chk("branchTaken_hold", bus.branchTaken, last_taken);
    end
  endtask

  // Drive one cycle, advance the reference queue, and check after the edge.
  task automatic step(input bit enq, input int addr, input bit pred,
                      input bit res, input bit taken, input bit fl);
    bit full_m, pop, mis, push;
    bus.enqValid = enq; bus.enqAddr = AW'(addr); bus.enqPred = pred;
    bus.resolveValid = res; bus.resolveTaken = taken; bus.flush = fl;
    full_m = (mq.size() == D);
    pop    = res && (mq.size() != 0);
    mis    = pop && (mq[0].pred != taken);
    push   = enq && (!full_m || pop) && !(fl || mis);
    if (pop) begin
      sb.push_back('{addr: mq[0].addr, taken: taken, mis: mis && !fl});
      void'(mq.pop_front());
    end
    if (fl || mis) mq.delete();
    else if (push) mq.push_back('{addr: addr, pred: pred});
    @(posedge clk); #1;
    check_outputs();
  endtask

  task automatic do_reset(input bit busy);
    bus.enqValid = busy; bus.enqAddr = AW'(3); bus.enqPred = 1;
    bus.resolveValid = busy; bus.resolveTaken = 0; bus.flush = busy;
    rst = 1;
    mq.delete(); sb.delete();
    last_addr = 0; last_taken = 0;
    @(posedge clk); #1;
    chk("rst_count", bus.count, 0);
    chk("rst_full", bus.full, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_update", bus.update, 0);
    chk("rst_updateAddr", bus.updateAddr, 0);
    chk("rst_branchTaken", bus.branchTaken, 0);
    chk("rst_mispredict", bus.mispredict, 0);
`ifdef BRQ_STATS_EN
    chk("rst_statResolved", bus.statResolved, 0);
    chk("rst_statMispredict", bus.statMispredict, 0);
`endif
    rst = 0;
    drive_idle();
  endtask

  function automatic vec_t v(bit enq, int addr, bit pred, bit res, bit taken, bit fl,
                             int ec, bit eu, bit em);
    return '{enq:enq, addr:addr, pred:pred, res:res, taken:taken, fl:fl,
             exp_count:ec, exp_update:eu, exp_mis:em};
  endfunction

  initial begin
    drive_idle();
    rst = 1;
    @(posedge clk);
    do_reset(0);

    //              enq addr pr res tk fl  cnt upd mis
    tbl.push_back(v(1,  5,   1, 0,  0, 0,  1,  0,  0)); // single push/resolve, correct
    tbl.push_back(v(0,  0,   0, 1,  1, 0,  0,  1,  0));
    tbl.push_back(v(1,  5,   1, 0,  0, 0,  1,  0,  0)); // mispredict discards 9
    tbl.push_back(v(1,  9,   0, 0,  0, 0,  2,  0,  0));
    tbl.push_back(v(1, 33,   1, 1,  0, 0,  0,  1,  1)); // same-cycle push dropped
    tbl.push_back(v(0,  0,   0, 0,  0, 0,  0,  0,  0));
    tbl.push_back(v(1,  1,   1, 0,  0, 0,  1,  0,  0)); // fill to full
    tbl.push_back(v(1,  2,   1, 0,  0, 0,  2,  0,  0));
    tbl.push_back(v(1,  3,   0, 0,  0, 0,  3,  0,  0));
    tbl.push_back(v(1,  4,   1, 0,  0, 0,  4,  0,  0));
    tbl.push_back(v(1,  7,   1, 0,  0, 0,  4,  0,  0)); // dropped while full
    tbl.push_back(v(1,  8,   0, 1,  1, 0,  4,  1,  0)); // pop+push while full
    tbl.push_back(v(0,  0,   0, 1,  1, 0,  3,  1,  0));
    tbl.push_back(v(0,  0,   0, 1,  0, 0,  2,  1,  0));
    tbl.push_back(v(0,  0,   0, 1,  1, 0,  1,  1,  0));
    tbl.push_back(v(0,  0,   0, 1,  0, 0,  0,  1,  0));
    tbl.push_back(v(0,  0,   0, 1,  1, 0,  0,  0,  0)); // resolve on empty
    tbl.push_back(v(1,  5,   1, 0,  0, 0,  1,  0,  0)); // flush + mispredicting pop
    tbl.push_back(v(1,  6,   0, 0,  0, 0,  2,  0,  0));
    tbl.push_back(v(1,  7,   1, 1,  0, 1,  0,  1,  0));
    tbl.push_back(v(0,  0,   0, 1,  1, 0,  0,  0,  0));
    tbl.push_back(v(1, 12,   1, 0,  0, 0,  1,  0,  0)); // plain flush
    tbl.push_back(v(0,  0,   0, 0,  0, 1,  0,  0,  0));

    foreach (tbl[i]) begin
      step(tbl[i].enq, tbl[i].addr, tbl[i].pred, tbl[i].res, tbl[i].taken, tbl[i].fl);
      chk($sformatf("tbl%0d_count", i), bus.count, tbl[i].exp_count);
      chk($sformatf("tbl%0d_update", i), bus.update, tbl[i].exp_update);
      chk($sformatf("tbl%0d_mis", i), bus.mispredict, tbl[i].exp_mis);
    end

    // Pointer wrap: overlapping push/pop pairs walk both pointers past DEPTH.
    step(1, 40, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 41 + i, 1, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    chk("wrap_lastAddr", bus.updateAddr, 46);
    chk("wrap_empty", bus.empty, 1);

    // Reset asserted while push/pop/flush are all active.
    step(1, 50, 0, 0, 0, 0);
    do_reset(1);
    step(0, 0, 0, 1, 1, 0);

`ifdef BRQ_STATS_EN
    for (int i = 0; i < 10; i++) begin
      step(1, 20 + i, 1, 0, 0, 0);
      step(0, 0, 0, 1, !(i == 1 || i == 4 || i == 7), 0);
    end
    chk("statResolved", bus.statResolved, 10);
    chk("statMispredict", bus.statMispredict, 3);
    step(1, 60, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1);
    chk("stat_keep_on_flush", bus.statResolved, 11);
    do_reset(1);
`endif

    drive_idle();
    step(0, 0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
